uart_ctrl: RTL and testbench
============================

# uart_ctrl

Host-facing controller that sequences the byte-level `uart` core. Buffers outbound bytes in a TX FIFO and issues one `transmit` pulse per byte when the core is idle. Drains received bytes into an RX FIFO with `recv_ack` handshaking. Exposes baud divisor, break and interrupt control through a small register port, and sits between the system bus adapter and one `uart` instance.

## Interface
- `TX_DEPTH`, 16 — TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 16 — RX FIFO entries; power of two, ≥2.
- `DEFAULT_BAUD`, 16'd1302 — BAUD register reset value.
- `clk` in 1 — single clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `addr` in 2 — register select: 0 DATA, 1 STATUS, 2 BAUD, 3 CTRL.
- `we` in 1 — write strobe, one cycle.
- `re` in 1 — read strobe, one cycle; `we` wins if both are asserted.
- `wdata` in 16 — write data.
- `rdata` out 16 — read data, registered.
- `irq` out 1 — level interrupt.
- `u_transmit` out 1 — to core `transmit`.
- `u_tx_byte` out 8 — to core `tx_byte`.
- `u_is_transmitting` in 1 — from core.
- `u_received` in 1 — from core.
- `u_rx_byte` in 8 — from core.
- `u_recv_error` in 1 — from core.
- `u_recv_ack` out 1 — to core `recv_ack`.
- `u_baud` out 16 — to core `baud`; equals BAUD register.
- `u_brk` out 1 — to core `brk`; equals CTRL.brk.

## Operation
- **Registers**
  - DATA write: push `wdata[7:0]` to the TX FIFO. If the FIFO is full, drop the byte and set sticky `tx_ovf`.
  - DATA read: pop the RX FIFO and return `{8'h00, byte}`. If the FIFO is empty, return 0 and pop nothing.
  - STATUS read bits:
    - [0] tx_full
    - [1] tx_empty
    - [2] rx_full
    - [3] rx_empty
    - [4] busy (TX FSM ≠ IDLE or `u_is_transmitting`)
    - [5] tx_ovf
    - [6] rx_ovf
    - [7] rx_err
  - STATUS write: bits 7:5 are write-1-to-clear.
  - BAUD: read/write 16 bits.
  - CTRL bits: [0] tx_en, [1] brk, [2] irq_rx_en, [3] irq_txe_en, [4] irq_err_en. Other bits read 0.
- **TX FSM**
  - IDLE → LOAD when tx_en && !tx_empty && !`u_is_transmitting`.
  - LOAD: `u_transmit`=1 for exactly one cycle; `u_tx_byte` = FIFO head, popped this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when `u_is_transmitting`=1.
  - WAIT_DONE → IDLE when `u_is_transmitting`=0.
  - `u_tx_byte` holds its value from LOAD until the next LOAD.
  - Clearing tx_en mid-byte finishes the current byte, then the FSM stays in IDLE.
- **RX path**
  - `u_recv_ack` = `u_received` | `u_recv_error` (combinational). The core flag is therefore seen for one cycle.
  - Push `u_rx_byte` when `u_received`=1. If the RX FIFO is full and not popped in the same cycle, drop the byte and set sticky `rx_ovf`.
  - `u_recv_error`=1 sets sticky `rx_err`.
- **irq** = (irq_rx_en & !rx_empty) | (irq_txe_en & tx_empty & TX FSM IDLE & !`u_is_transmitting`) | (irq_err_en & (tx_ovf|rx_ovf|rx_err)).
- **FIFO boundary cases**
  - Push and pop in the same cycle on a full FIFO: both succeed.
  - Push and pop in the same cycle on an empty FIFO: the pop returns 0 and the push succeeds.
  - Pointers wrap modulo depth; the count is log2(depth)+1 bits.
- **Simultaneous events:** a sticky-bit set and a W1C clear in the same cycle leave the bit set.

## Timing
- Reset values:
  - rdata=0, irq=0
  - u_transmit=0, u_tx_byte=0, u_recv_ack follows inputs
  - u_baud=DEFAULT_BAUD, u_brk=0
  - CTRL=0, sticky bits=0, both FIFOs empty, TX FSM=IDLE
- Reset assertion mid-operation clears everything immediately, including FIFO contents. `u_transmit` drops asynchronously.
- `rdata` is valid the cycle after `re`. Register writes take effect the cycle after `we`.
- A DATA write into an idle controller with tx_en=1 produces `u_transmit` 2 cycles after `we`: FIFO non-empty at +1, LOAD at +2.
- A received byte is readable through DATA the cycle after `u_received`.

## Configuration
- `UART_CTRL_RX_FIFO_EN` defined: RX buffer is a FIFO of RX_DEPTH entries.
- Not defined: RX buffer is a single holding register.
  - rx_full = !rx_empty.
  - A second byte arriving before the read sets rx_ovf and is dropped.
  - RX_DEPTH is ignored.

## Structure
- `uart_ctrl_pkg`:
  - register address constants
  - STATUS and CTRL bit indices
  - TX FSM state enum (IDLE, LOAD, WAIT_BUSY, WAIT_DONE)
- One sub-module, `uart_ctrl_fifo` (parameterised width and depth, async active-low reset). It is instantiated for TX, and for RX when the macro is enabled.

## Test plan
- Write CTRL=1, then DATA writes 0x55, 0xA3 with a core model busy 40 cycles per byte → two `u_transmit` pulses with u_tx_byte 0x55 then 0xA3, second pulse only after `u_is_transmitting` falls.
- TX_DEPTH=16: 17 DATA writes with tx_en=0 → STATUS reads tx_full=1, tx_ovf=1; write STATUS 0x20 → tx_ovf=0.
- Pulse `u_received` with byte 0x3C → `u_recv_ack` same cycle; irq=1 when irq_rx_en; DATA read returns 0x003C and rx_empty=1.
- Macro enabled: 17 received bytes unread → rx_ovf=1 and the first 16 bytes are read back in order. Macro disabled: 2 unread bytes → rx_ovf=1 and 1st byte read back.
- `u_recv_error` pulse with irq_err_en=1 → rx_err=1, irq=1, `u_recv_ack`=1 that cycle.
- Write BAUD=0x0010 and CTRL.brk=1 → u_baud=0x0010, u_brk=1. Then assert rst_n=0 mid-transmission → u_transmit=0, u_baud=1302, u_brk=0, FIFOs empty.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, STATUS/CTRL bit positions and TX FSM states
// shared by the uart_ctrl controller and its FIFO.
package uart_ctrl_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit indices
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;
  localparam int ST_RX_ERR   = 7;

  // CTRL bit indices
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_BRK     = 1;
  localparam int CTRL_IRQ_RX  = 2;
  localparam int CTRL_IRQ_TXE = 3;
  localparam int CTRL_IRQ_ERR = 4;
  localparam int CTRL_W       = 5;

  // TX sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on an empty FIFO
// does nothing.
module uart_ctrl_fifo
  import uart_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: register front-end that feeds the byte-level uart core from a TX
// FIFO and buffers received bytes. Macro UART_CTRL_RX_FIFO_EN selects an
// RX_DEPTH-entry RX FIFO; otherwise RX uses a single holding register.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] DEFAULT_BAUD = 16'd1302
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        u_transmit,
  output logic [7:0]  u_tx_byte,
  input  logic        u_is_transmitting,
  input  logic        u_received,
  input  logic [7:0]  u_rx_byte,
  input  logic        u_recv_error,
  output logic        u_recv_ack,
  output logic [15:0] u_baud,
  output logic        u_brk
);

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_ctrl: FIFO depths must be powers of two and at least 2");
  end

  tx_state_e         state_q, state_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [15:0]       baud_q, baud_d, rdata_q, rdata_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_err_q, rx_err_d;

  logic       wr_data, wr_status, rd_en, rd_data;
  logic       tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0] tx_head, rx_head;
  logic       rx_pop, rx_full, rx_empty, rx_drop, busy;
  logic [7:0] status;

  assign wr_data   = we && (addr == ADDR_DATA);
  assign wr_status = we && (addr == ADDR_STATUS);
  assign rd_en     = re && !we;
  assign rd_data   = rd_en && (addr == ADDR_DATA);
  assign tx_pop    = (state_q == LOAD);
  assign tx_drop   = wr_data && tx_full && !tx_pop;
  assign rx_pop    = rd_data;
  assign busy      = (state_q != IDLE) || u_is_transmitting;

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(wr_data), .push_data(wdata[7:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

`ifdef UART_CTRL_RX_FIFO_EN
  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(u_received), .push_data(u_rx_byte),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  assign rx_drop = u_received && rx_full && !rx_pop;
`else
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  assign rx_empty = !rx_valid_q;
  assign rx_full  = rx_valid_q;
  assign rx_head  = rx_byte_q;
  assign rx_drop  = u_received && rx_valid_q && !rx_pop;

  // Single-slot RX buffer: a new byte is taken when the slot is free or being read.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    if (rx_pop) rx_valid_d = 1'b0;
    if (u_received && (!rx_valid_q || rx_pop)) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = u_rx_byte;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
    end
  end
`endif

  assign status = {rx_err_q, rx_ovf_q, tx_ovf_q, busy, rx_empty, rx_full, tx_empty, tx_full};

  // Register writes, sticky flags (a set beats a same-cycle clear) and read mux.
  always_comb begin
    baud_d   = baud_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;
    tx_ovf_d = (tx_ovf_q && !(wr_status && wdata[ST_TX_OVF])) || tx_drop;
    rx_ovf_d = (rx_ovf_q && !(wr_status && wdata[ST_RX_OVF])) || rx_drop;
    rx_err_d = (rx_err_q && !(wr_status && wdata[ST_RX_ERR])) || u_recv_error;
    if (we && addr == ADDR_BAUD) baud_d = wdata;
    if (we && addr == ADDR_CTRL) ctrl_d = wdata[CTRL_W-1:0];
    if (rd_en) begin
      case (addr)
        ADDR_DATA:   rdata_d = rx_empty ? 16'h0000 : {8'h00, rx_head};
        ADDR_STATUS: rdata_d = {8'h00, status};
        ADDR_BAUD:   rdata_d = baud_q;
        default:     rdata_d = {{(16 - CTRL_W){1'b0}}, ctrl_q};
      endcase
    end
  end

  // TX sequencing: one transmit pulse per byte, then track the core's busy flag.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      IDLE:      if (ctrl_q[CTRL_TX_EN] && !tx_empty && !u_is_transmitting) state_d = LOAD;
      LOAD: begin
        tx_byte_d = tx_head;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: if (u_is_transmitting)  state_d = WAIT_DONE;
      WAIT_DONE: if (!u_is_transmitting) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
      baud_q    <= DEFAULT_BAUD;
      ctrl_q    <= '0;
      rdata_q   <= 16'h0000;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      baud_q    <= baud_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      rx_err_q  <= rx_err_d;
    end
  end

  // The byte presented to the core is the FIFO head during LOAD, then held.
  assign u_transmit = tx_pop;
  assign u_tx_byte  = tx_pop ? tx_head : tx_byte_q;
  assign u_recv_ack = u_received | u_recv_error;
  assign u_baud     = baud_q;
  assign u_brk      = ctrl_q[CTRL_BRK];
  assign rdata      = rdata_q;
  assign irq = (ctrl_q[CTRL_IRQ_RX] && !rx_empty) ||
               (ctrl_q[CTRL_IRQ_TXE] && tx_empty && state_q == IDLE && !u_is_transmitting) ||
               (ctrl_q[CTRL_IRQ_ERR] && (tx_ovf_q || rx_ovf_q || rx_err_q));

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: randomized self-checking bench for uart_ctrl with a
// queue-based register model and a behavioural uart core model.
module tb_uart_ctrl;
  import uart_ctrl_pkg::*;

  localparam int TXD = 16;
`ifdef UART_CTRL_RX_FIFO_EN
  localparam int RX_CAP = 16;
`else
  localparam int RX_CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we, re;
  logic [15:0] wdata, rdata;
  logic        irq, u_transmit, u_is_transmitting, u_received, u_recv_error, u_recv_ack, u_brk;
  logic [7:0]  u_tx_byte, u_rx_byte;
  logic [15:0] u_baud;

  uart_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .irq(irq), .u_transmit(u_transmit), .u_tx_byte(u_tx_byte),
    .u_is_transmitting(u_is_transmitting), .u_received(u_received),
    .u_rx_byte(u_rx_byte), .u_recv_error(u_recv_error), .u_recv_ack(u_recv_ack),
    .u_baud(u_baud), .u_brk(u_brk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        m_tx_ovf, m_rx_ovf, m_rx_err;
  logic [4:0]  m_ctrl;
  logic [15:0] m_baud;

  // Core model observations
  logic [7:0] tx_seen[$];
  int         pulse_cyc[$];
  int         busy_len = 4;
  int         last_we_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] m_status();
    return {8'h00, m_rx_err, m_rx_ovf, m_tx_ovf, 1'b0,
            rxq.size() == 0, rxq.size() == RX_CAP, txq.size() == 0, txq.size() == TXD};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[2] && rxq.size() != 0) || (m_ctrl[3] && txq.size() == 0) ||
           (m_ctrl[4] && (m_tx_ovf || m_rx_ovf || m_rx_err));
  endfunction

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_err = 0; m_ctrl = '0; m_baud = 16'd1302;
  endtask

  // Bus write; called and returning just after a falling edge.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1; last_we_cyc = cyc;
    @(negedge clk);
    we = 1'b0;
    case (a)
      ADDR_DATA:   if (txq.size() < TXD) txq.push_back(d[7:0]); else m_tx_ovf = 1;
      ADDR_STATUS: begin
        if (d[5]) m_tx_ovf = 0;
        if (d[6]) m_rx_ovf = 0;
        if (d[7]) m_rx_err = 0;
      end
      ADDR_BAUD:   m_baud = d;
      default:     m_ctrl = d[4:0];
    endcase
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic chk_status(input string tag);
    logic [15:0] v;
    rd(ADDR_STATUS, v);
    check(tag, v, m_status());
  endtask

  task automatic rd_data_chk(input string tag);
    logic [15:0] v, e;
    e = (rxq.size() != 0) ? {8'h00, rxq.pop_front()} : 16'h0000;
    rd(ADDR_DATA, v);
    check(tag, v, e);
  endtask

  task automatic recv(input logic [7:0] b);
    u_received = 1'b1; u_rx_byte = b;
    #1 check("recv_ack", u_recv_ack, 1);
    @(negedge clk);
    u_received = 1'b0;
    #1 check("recv_ack_low", u_recv_ack, 0);
    if (rxq.size() < RX_CAP) rxq.push_back(b); else m_rx_ovf = 1;
  endtask

  task automatic recv_err();
    u_recv_error = 1'b1;
    #1 check("err_ack", u_recv_ack, 1);
    @(negedge clk);
    u_recv_error = 1'b0;
    m_rx_err = 1;
  endtask

  // DATA read and byte arrival in the same cycle.
  task automatic rd_recv(input string tag, input logic [7:0] b);
    logic [15:0] e;
    e = (rxq.size() != 0) ? {8'h00, rxq.pop_front()} : 16'h0000;
    addr = ADDR_DATA; re = 1'b1; u_received = 1'b1; u_rx_byte = b;
    @(negedge clk);
    re = 1'b0; u_received = 1'b0;
    check(tag, rdata, e);
    if (rxq.size() < RX_CAP) rxq.push_back(b); else m_rx_ovf = 1;
  endtask

  task automatic rx_readout();
    int n;
    n = rxq.size();
    for (int i = 0; i <= n; i++) rd_data_chk($sformatf("rx_data%0d", i));
  endtask

  // Wait for the model's pending TX bytes to leave, in order.
  task automatic drain_check();
    int  n;
    bit  done;
    n = txq.size();
    done = 0;
    for (int c = 0; c < 4000; c++) begin
      if (tx_seen.size() == n && !u_is_transmitting) begin done = 1; break; end
      @(negedge clk);
    end
    check("tx_drain_done", done, 1);
    repeat (3) @(negedge clk);
    check("tx_count", tx_seen.size(), n);
    for (int i = 0; i < n && i < tx_seen.size(); i++)
      check($sformatf("tx_byte%0d", i), tx_seen[i], txq[i]);
    txq.delete();
    tx_seen.delete();
    pulse_cyc.delete();
  endtask

  // Behavioural uart core: busy for busy_len cycles after each transmit pulse.
  initial begin
    u_is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && u_transmit) begin
        tx_seen.push_back(u_tx_byte);
        pulse_cyc.push_back(cyc);
        u_is_transmitting = 1'b1;
        for (int k = 0; k < busy_len; k++) begin
          @(negedge clk);
          if (!rst_n) break;
          check("no_tx_while_busy", u_transmit, 0);
        end
        u_is_transmitting = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          we0, n, m;
    logic [4:0]  cv;

    rst_n = 1'b0; addr = '0; we = 0; re = 0; wdata = '0;
    u_received = 0; u_rx_byte = '0; u_recv_error = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_transmit", u_transmit, 0);
    check("rst_tx_byte", u_tx_byte, 0);
    check("rst_baud", u_baud, 16'd1302);
    check("rst_brk", u_brk, 0);
    check("rst_ack", u_recv_ack, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_status("rst_status");
    rd(ADDR_CTRL, v);  check("rst_ctrl", v, 0);
    rd(ADDR_BAUD, v);  check("rst_baud_reg", v, 16'd1302);

    // Two bytes with a 40-cycle core.
    busy_len = 40;
    wr(ADDR_CTRL, 16'h0001);
    wr(ADDR_DATA, 16'h0055);
    we0 = last_we_cyc;
    wr(ADDR_DATA, 16'h00A3);
    repeat (2) @(negedge clk);
    check("tx_latency", (pulse_cyc.size() > 0) ? pulse_cyc[0] - we0 : -1, 2);
    repeat (45) @(negedge clk);
    check("tx_gap", (pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1, 42);
    drain_check();
    wr(ADDR_CTRL, 16'h0000);
    chk_status("tx_done_status");

    // TX overflow and W1C.
    for (int i = 0; i < 17; i++) wr(ADDR_DATA, 16'(i + 8'h80));
    chk_status("tx_full_ovf");
    wr(ADDR_STATUS, 16'h0020);
    chk_status("tx_ovf_clr");
    busy_len = 3;
    wr(ADDR_CTRL, 16'h0001);
    drain_check();
    wr(ADDR_CTRL, 16'h0004);

    // Single received byte with irq_rx_en.
    recv(8'h3C);
    check("rx_irq", irq, 1);
    rd_data_chk("rx_3c");
    chk_status("rx_empty_after");

    // Overflow the RX buffer by one.
    for (int i = 0; i <= RX_CAP; i++) recv(8'(8'h10 + i));
    chk_status("rx_ovf_status");
    rx_readout();
    wr(ADDR_STATUS, 16'h00E0);

    // Receive error, and an error colliding with its own W1C clear.
    wr(ADDR_CTRL, 16'h0010);
    recv_err();
    check("err_irq", irq, 1);
    chk_status("err_status");
    addr = ADDR_STATUS; wdata = 16'h0080; we = 1'b1; u_recv_error = 1'b1;
    @(negedge clk);
    we = 1'b0; u_recv_error = 1'b0;
    chk_status("err_set_wins");
    wr(ADDR_STATUS, 16'h0080);
    chk_status("err_cleared");
    check("err_irq_low", irq, 0);

    // Read and arrival together: on an empty buffer, then on a full one.
    rd_recv("rdrecv_empty", 8'hC1);
    for (int i = rxq.size(); i < RX_CAP; i++) recv(8'($urandom));
    rd_recv("rdrecv_full", 8'hC2);
    chk_status("rdrecv_status");
    rx_readout();

    // Randomized rounds.
    for (int it = 0; it < 6; it++) begin
      cv = {3'($urandom), 1'($urandom), 1'b0};
      wr(ADDR_CTRL, {11'd0, cv});
      check("brk_out", u_brk, cv[1]);
      n = $urandom_range(0, 19);
      for (int i = 0; i < n; i++) wr(ADDR_DATA, 16'($urandom));
      check("irq_a", irq, m_irq());
      chk_status("stat_a");
      wr(ADDR_STATUS, {8'h00, 3'($urandom), 5'h00});
      chk_status("stat_w1c");
      busy_len = $urandom_range(2, 6);
      wr(ADDR_CTRL, {11'd0, cv | 5'b00001});
      drain_check();
      wr(ADDR_CTRL, {11'd0, cv});
      check("irq_b", irq, m_irq());
      chk_status("stat_b");
      m = $urandom_range(0, RX_CAP + 2);
      for (int i = 0; i < m; i++) begin
        recv(8'($urandom));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      if ($urandom_range(0, 3) == 0) recv_err();
      check("irq_c", irq, m_irq());
      chk_status("stat_c");
      rx_readout();
      chk_status("stat_d");
      v = 16'($urandom);
      wr(ADDR_BAUD, v);
      check("baud_out", u_baud, m_baud);
      wr(ADDR_STATUS, 16'h00E0);
    end

    // BAUD/brk, then reset in the middle of a transmission.
    wr(ADDR_BAUD, 16'h0010);
    wr(ADDR_CTRL, 16'h0003);
    check("baud_0010", u_baud, 16'h0010);
    check("brk_on", u_brk, 1);
    busy_len = 20;
    wr(ADDR_DATA, 16'h0011);
    wr(ADDR_DATA, 16'h0022);
    wr(ADDR_DATA, 16'h0033);
    recv(8'h44);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (u_transmit && pulse_cyc.size() >= 1) begin n = 1; break; end
    end
    check("second_pulse_seen", n, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_transmit", u_transmit, 0);
    check("arst_baud", u_baud, 16'd1302);
    check("arst_brk", u_brk, 0);
    check("arst_irq", irq, 0);
    check("arst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tx_seen.delete();
    pulse_cyc.delete();
    @(negedge clk);
    check("arst_tx_byte", u_tx_byte, 0);
    chk_status("arst_status");
    rd_data_chk("arst_rx_empty");
    repeat (5) @(negedge clk);
    check("arst_no_tx", tx_seen.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
